// File: rtl/clock_divider_multi.sv
// clock_divider_multi: multi-channel glitch-free integer clock divider with shadowed factor/mode
//   clk_ip     : input clock, all state on rising edge
//   rst        : asynchronous active-low reset
//   en         : per-channel run enable
//   load       : per-channel strobe capturing factor_bus slice and mode bit into the shadow
//   factor_bus : concatenated per-channel division factors
//   mode       : per-channel 0 = square, 1 = single-cycle pulse
//   sync       : restart all running channels in phase
//   clk_op     : divided outputs (registered)
//   tick       : first-cycle-of-period strobe (registered)
//   pending    : shadow holds a value not yet applied
module clock_divider_multi #(
  parameter int CHANNELS       = 4,
  parameter int FACTOR_W       = 8,
  parameter int DEFAULT_FACTOR = 2
) (
  input  logic                         clk_ip,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          en,
  input  logic [CHANNELS-1:0]          load,
  input  logic [CHANNELS*FACTOR_W-1:0] factor_bus,
  input  logic [CHANNELS-1:0]          mode,
  input  logic                         sync,
  output logic [CHANNELS-1:0]          clk_op,
  output logic [CHANNELS-1:0]          tick,
  output logic [CHANNELS-1:0]          pending
);
  typedef enum logic [1:0] {IDLE, RUN, PARK} state_t;
  localparam logic [FACTOR_W-1:0] ONE = 1;
  localparam logic [FACTOR_W:0] ONE_X = 1;
  localparam logic [FACTOR_W-1:0] DEF = DEFAULT_FACTOR[FACTOR_W-1:0];
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t state_q, state_d;
    logic [FACTOR_W-1:0] cnt_q, cnt_d, n_q, n_d, ns_q, ns_d;
    logic m_q, m_d, ms_q, ms_d;
    logic pending_q, pending_d, clk_op_q, clk_op_d, tick_q, tick_d;
    logic [FACTOR_W:0] high_len;
    logic last, start;
    // high length is one bit wider so N = 2^FACTOR_W-1 does not overflow on +1
    assign high_len = m_q ? ONE_X : ({1'b0, n_q} + ONE_X) >> 1;
    assign last = cnt_q == n_q - ONE;
    // a restart always uses the shadow as it stood before this edge's load
    assign start = en[c] && (state_q == IDLE || (state_q == PARK && ns_q != '0) ||
                             (state_q == RUN && (sync || last)));
    always_comb begin
      ns_d      = load[c] ? factor_bus[c*FACTOR_W +: FACTOR_W] : ns_q;
      ms_d      = load[c] ? mode[c] : ms_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      n_d       = n_q;
      m_d       = m_q;
      pending_d = load[c] | pending_q;
      clk_op_d  = 1'b0;
      tick_d    = 1'b0;
      if (!en[c]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (start) begin
        n_d       = ns_q;
        m_d       = ms_q;
        pending_d = load[c];
        cnt_d     = '0;
        state_d   = ns_q == '0 ? PARK : RUN;
        clk_op_d  = ns_q != '0;
        tick_d    = ns_q != '0;
      end else if (state_q == RUN) begin
        cnt_d    = cnt_q + ONE;
        clk_op_d = {1'b0, cnt_d} < high_len;
      end
    end
    always_ff @(posedge clk_ip or negedge rst) begin
      if (!rst) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        n_q       <= DEF;
        ns_q      <= DEF;
        m_q       <= 1'b0;
        ms_q      <= 1'b0;
        pending_q <= 1'b0;
        clk_op_q  <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        n_q       <= n_d;
        ns_q      <= ns_d;
        m_q       <= m_d;
        ms_q      <= ms_d;
        pending_q <= pending_d;
        clk_op_q  <= clk_op_d;
        tick_q    <= tick_d;
      end
    end
    assign clk_op[c]  = clk_op_q;
    assign tick[c]    = tick_q;
    assign pending[c] = pending_q;
  end
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed and randomized checks of clock_divider_multi against a period-position model
module tb_clock_divider_multi;
  localparam int CH = 4, FW = 8, DEF = 2;
  logic clk_ip = 1'b0, rst = 1'b0, sync = 1'b0;
  logic [CH-1:0] en = '0, load = '0, mode = '0;
  logic [CH*FW-1:0] factor_bus = '0;
  logic [CH-1:0] clk_op, tick, pending;
  int checks = 0, errors = 0;
  int act_n[CH], act_m[CH], sh_n[CH], sh_m[CH], pend[CH], active[CH], phase[CH];
  clock_divider_multi #(.CHANNELS(CH), .FACTOR_W(FW), .DEFAULT_FACTOR(DEF)) dut (
    .clk_ip(clk_ip), .rst(rst), .en(en), .load(load), .factor_bus(factor_bus),
    .mode(mode), .sync(sync), .clk_op(clk_op), .tick(tick), .pending(pending)
  );
  always #5 clk_ip = ~clk_ip;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      act_n[c] = DEF; sh_n[c] = DEF; act_m[c] = 0; sh_m[c] = 0;
      pend[c] = 0; active[c] = 0; phase[c] = 0;
    end
  endtask
  // phase = cycles since the current period started; a new period takes the shadow values
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit restart;
      if (!en[c]) begin
        active[c] = 0; phase[c] = 0;
      end else begin
        restart = active[c] == 0 || (act_n[c] == 0 && sh_n[c] != 0) ||
                  (act_n[c] != 0 && (sync || phase[c] == act_n[c] - 1));
        if (restart) begin
          act_n[c] = sh_n[c]; act_m[c] = sh_m[c]; pend[c] = 0; phase[c] = 0; active[c] = 1;
        end else if (act_n[c] != 0) phase[c]++;
      end
      if (load[c]) begin
        sh_n[c] = int'(factor_bus[c*FW +: FW]); sh_m[c] = int'(mode[c]); pend[c] = 1;
      end
    end
  endtask
  function automatic logic [CH-1:0] exp_clk();
    logic [CH-1:0] e;
    for (int c = 0; c < CH; c++)
      e[c] = active[c] != 0 && act_n[c] != 0 &&
             phase[c] < (act_m[c] != 0 ? 1 : (act_n[c] + 1) / 2);
    return e;
  endfunction
  function automatic logic [CH-1:0] exp_tick();
    logic [CH-1:0] e;
    for (int c = 0; c < CH; c++) e[c] = active[c] != 0 && act_n[c] != 0 && phase[c] == 0;
    return e;
  endfunction
  function automatic logic [CH-1:0] exp_pend();
    logic [CH-1:0] e;
    for (int c = 0; c < CH; c++) e[c] = pend[c] != 0;
    return e;
  endfunction
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_ip);
      model_step();
      #1;
      check("clk_op", clk_op, exp_clk());
      check("tick", tick, exp_tick());
      check("pending", pending, exp_pend());
      load = '0;
      sync = 1'b0;
    end
  endtask
  task automatic ld(input int c, input int f, input bit m);
    load[c] = 1'b1;
    factor_bus[c*FW +: FW] = f[FW-1:0];
    mode[c] = m;
  endtask
  initial begin
    model_reset();
    #12;
    check("rst_clk", clk_op, 0);
    check("rst_tick", tick, 0);
    check("rst_pend", pending, 0);
    @(posedge clk_ip); #1 rst = 1'b1;
    // factor 5 square
    ld(0, 5, 0); cyc(1);
    check("pend_load", pending[0], 1);
    en[0] = 1'b1; cyc(1);
    check("start_clk", clk_op[0], 1);
    check("start_pend", pending[0], 0);
    cyc(12);
    // N=8, then load 10 mid-period
    ld(0, 8, 0); cyc(10);
    for (int k = 0; k < 40 && phase[0] != 3; k++) cyc(1);
    ld(0, 10, 0); cyc(25);
    // load coincident with a wrap edge
    for (int k = 0; k < 40 && phase[0] != act_n[0] - 1; k++) cyc(1);
    ld(0, 4, 0); cyc(1);
    check("pend_wrap", pending[0], 1);
    check("old_n_kept", tick[0], 1);
    cyc(25);
    // sync with two pulse-mode channels, ch2 idle
    ld(0, 6, 1); ld(1, 4, 1); cyc(1);
    en = 4'b0011; cyc(15);
    sync = 1'b1; cyc(1);
    check("sync_tick", tick[1:0], 2'b11);
    check("idle_ch2", {clk_op[2], tick[2]}, 0);
    cyc(24);
    // factor 1, then 0 (park), then 3
    ld(0, 1, 0); cyc(15);
    check("n1_clk", clk_op[0], 1);
    check("n1_tick", tick[0], 1);
    ld(0, 0, 0); cyc(5);
    check("park_clk", clk_op[0], 0);
    ld(0, 3, 0); cyc(1);
    check("park_hold", clk_op[0], 0);
    cyc(1);
    check("unpark_clk", clk_op[0], 1);
    cyc(8);
    // asynchronous reset mid-period
    ld(0, 5, 0); cyc(1);
    for (int k = 0; k < 40 && phase[0] != 2; k++) cyc(1);
    #2 rst = 1'b0;
    #1;
    check("async_clk", clk_op, 0);
    check("async_tick", tick, 0);
    check("async_pend", pending, 0);
    model_reset();
    en = '0;
    repeat (2) @(posedge clk_ip);
    #1 rst = 1'b1;
    cyc(2);
    en = 4'b0001; cyc(10);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) begin
        int r;
        en[c] = $urandom_range(0, 19) != 0;
        if ($urandom_range(0, 7) == 0) begin
          r = $urandom_range(0, 19);
          ld(c, r < 2 ? 0 : r < 4 ? 1 : r == 19 ? 255 : int'($urandom_range(2, 12)),
             bit'($urandom_range(0, 1)));
        end
      end
      sync = $urandom_range(0, 29) == 0;
      cyc(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Parametrised multi-channel integer clock divider: the successor to the single-channel `Clock_Divider`. Each of `CHANNELS` independent channels divides `clk_ip` by a per-channel `FACTOR_W`-bit factor. Each channel has:
- a square (≈50 % duty) or single-cycle pulse output mode;
- factor/mode updates that take effect only at a period boundary, so outputs never glitch;
- a period-start strobe.

A global `sync` restarts all channels in phase. The block sits in the clock-management area and feeds clock-enable style signals to downstream logic in the `clk_ip` domain.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent divider channels (≥1).
- `FACTOR_W`, 8: width of each division factor (≥2).
- `DEFAULT_FACTOR`, 2: shadow/active factor value after reset. Must be <2^FACTOR_W.

Ports:
- `clk_ip`  in  1  input clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  CHANNELS  per-channel run enable; bit i controls channel i.
- `load`  in  CHANNELS  per-channel one-cycle strobe: capture `factor_bus` slice i and `mode` bit i into channel i's shadow.
- `factor_bus`  in  CHANNELS*FACTOR_W  concatenated factors; channel i uses bits [i*FACTOR_W +: FACTOR_W].
- `mode`  in  CHANNELS  0 = square output, 1 = pulse output; captured with `load`.
- `sync`  in  1  one-cycle strobe: restart all running channels at count 0.
- `clk_op`  out  CHANNELS  divided outputs, registered.
- `tick`  out  CHANNELS  one-cycle pulse on the first cycle of each output period, registered.
- `pending`  out  CHANNELS  shadow holds a loaded value not yet applied.

## Operation
- Per-channel state:
  - `cnt` (FACTOR_W bits);
  - active factor `N` and active mode `M`;
  - shadow factor `Ns` and shadow mode `Ms`;
  - `run`, `pending`, `clk_op`, `tick`.
- High length `H`: M=0 → `(N+1)>>1`; M=1 → 1. `clk_op` is high while `cnt < H`, so odd N in square mode is high (N+1)/2 cycles and low (N−1)/2 cycles.
- States per channel:
  - IDLE: `run`=0, `cnt`=0, `clk_op`=0, `tick`=0.
  - RUN.
  - PARK: running with N=0; outputs low.
- IDLE → RUN: on an edge with `en`=1. At that edge `N`←`Ns`, `M`←`Ms`, `pending`←0, `cnt`←0, `clk_op`←1, `tick`←1. If `Ns`=0, the channel enters PARK instead, with outputs 0.
- RUN counting, each edge: `cnt` ← (`cnt`==N−1) ? 0 : `cnt`+1. `clk_op` and `tick` are computed from the next `cnt`: `tick` ← (next `cnt`==0).
- Wrap edge (`cnt`==N−1): `N`←`Ns`, `M`←`Ms`, `pending`←0. The new period uses the new values immediately.
- `load[i]` at an edge: `Ns`←slice, `Ms`←`mode[i]`, `pending`←1.
  - If this edge is also a wrap, IDLE→RUN or `sync` edge, those use the OLD shadow; `pending` stays 1.
- N=1: `clk_op` is constantly 1 and `tick` is 1 every cycle while running, regardless of M.
- PARK: `clk_op`=0, `tick`=0. Re-evaluated every edge; when `Ns`≠0 the channel takes the IDLE→RUN actions.
- `sync`=1 at an edge: every channel in RUN takes the IDLE→RUN actions (restart, apply shadow). IDLE channels are unaffected.
- `en[i]`=0 at any edge: channel goes to IDLE next cycle. This overrides `sync`, wrap and `load` application. `load` still writes the shadow.
- Factor arithmetic is unsigned, FACTOR_W bits; maximum N = 2^FACTOR_W − 1. `cnt` never exceeds N−1.

## Timing
- Reset (`rst`=0, asynchronous):
  - `clk_op`=0, `tick`=0, `pending`=0, `cnt`=0;
  - all channels IDLE;
  - `N`=`Ns`=DEFAULT_FACTOR, `M`=`Ms`=0.
- Reset deassertion is followed by normal operation from the next rising edge.
- Start latency: `en` sampled high at edge k → `clk_op`=1 and `tick`=1 after edge k.
- Output period is exactly N `clk_ip` cycles; consecutive `tick`s are N cycles apart.
- Factor change latency: applied at the first wrap edge strictly after the `load` edge. Worst case N_old cycles.
- Reset mid-period: outputs drop to 0 immediately, without waiting for a clock edge. No partial period resumes.

## Test plan
- Reset, `load` ch0 factor=5 mode=0, `en[0]`=1 → `clk_op[0]` pattern 1,1,1,0,0 repeating; `tick[0]` every 5 cycles; `pending[0]` clears on start.
- ch0 running N=8 square, `load` 10 at cnt=3 → remaining 4 cycles of the N=8 period unchanged (4 high/4 low). Next period is 5 high/5 low. `pending` is high from the load until the wrap edge.
- `load` coincident with a wrap edge → old factor used for one more period, `pending` stays 1, new factor applied at the following wrap.
- ch0 N=6, ch1 N=4, both pulse mode, `sync` pulse → both `tick` high on the same cycle, then ch0 every 6 cycles and ch1 every 4. An IDLE ch2 stays low.
- `load` factor=1 → `clk_op` constant 1 and `tick` every cycle. `load` factor=0 → PARK with outputs 0 at the next wrap; `load` factor=3 while parked → restart next edge with pattern 1,1,0.
- Assert `rst` low mid-period (N=5, cnt=2) → `clk_op`/`tick` 0 without a clock edge. After release, the channel is IDLE with N=DEFAULT_FACTOR.
